controle_multiciclo: RTL and testbench

//  Parametrised multi-cycle control unit; successor of the single-cycle opcode decoder.
//  FSM sequences BUSCA/DECOD/EXEC/MEM/ESCRITA per instruction, adding a memory handshake, timeout and illegal-opcode trap.

---
 rtl/controle_multiciclo.sv | 150 +++++++++++++++
 tb/tb_controle_multiciclo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit: fetch/decode/execute/memory/write-back sequencing with
// memory handshake, wait timeout, illegal-opcode trap and a retired-instruction counter.
module controle_multiciclo #(
   parameter int OPCODE_W = 3,
   parameter int TIMEOUT  = 15,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] OpCode,
   input  logic                MemPronto,
   output logic                Halt,
   output logic                RegFonte,
   output logic                RegDst,
   output logic                EscReg,
   output logic                ULA1,
   output logic                ULA2,
   output logic                Beq,
   output logic                Salto,
   output logic                Set,
   output logic                LerMem,
   output logic                EscMem,
   output logic [2:0]          ULAOp,
   output logic                EscIR,
   output logic                EscPC,
   output logic                Erro,
   output logic [2:0]          Estado,
   output logic [CNT_W-1:0]    InstrCount
);

   // state   | meaning
   // BUSCA   | fetch, wait for MemPronto, load IR
   // DECOD   | latch opcode, trap illegal, catch hlt
   // EXEC    | ALU step; branches and jumps retire here
   // MEM     | load/store handshake
   // ESCRITA | register write-back, retire
   // PARADO  | halted or trapped; left only by reset
   typedef enum logic [2:0] {
      BUSCA   = 3'd0,
      DECOD   = 3'd1,
      EXEC    = 3'd2,
      MEM     = 3'd3,
      ESCRITA = 3'd4,
      PARADO  = 3'd5
   } state_t;

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(TIMEOUT);

   state_t            state, state_next;
   logic [2:0]        op_r;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W:0]   wait_inc;
   logic              waiting, timed_out, illegal, trap;

   assign wait_inc  = {1'b0, wait_cnt} + 1'b1;
   assign waiting   = ((state == BUSCA) || (state == MEM)) && !MemPronto;
   // Trap on the cycle that would make the wait count reach TIMEOUT.
   assign timed_out = waiting && (TIMEOUT > 0) && (wait_inc == TIMEOUT_V);
   assign illegal   = ((OpCode >> 3) != '0) || (OpCode[2:0] == 3'b110);

   always_ff @(posedge clock) begin
      if (!reset) state <= BUSCA;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      trap       = 1'b0;
      case (state)
         BUSCA: begin
            if (MemPronto)      state_next = DECOD;
            else if (timed_out) begin state_next = PARADO; trap = 1'b1; end
         end
         DECOD: begin
            if (illegal) begin state_next = PARADO; trap = 1'b1; end
            else if (OpCode[2:0] == 3'b111) state_next = PARADO;
            else                            state_next = EXEC;
         end
         EXEC: begin
            case (op_r)
               3'b000, 3'b001: state_next = MEM;
               3'b010, 3'b101: state_next = ESCRITA;
               default:        state_next = BUSCA;
            endcase
         end
         MEM: begin
            if (MemPronto)      state_next = (op_r == 3'b000) ? ESCRITA : BUSCA;
            else if (timed_out) begin state_next = PARADO; trap = 1'b1; end
         end
         ESCRITA: state_next = BUSCA;
         PARADO:  state_next = PARADO;
         default: state_next = BUSCA;
      endcase
   end

   always_comb begin
      Halt = 1'b0; RegFonte = 1'b0; RegDst = 1'b0; EscReg = 1'b0;
      ULA1 = 1'b0; ULA2 = 1'b0; Beq = 1'b0; Salto = 1'b0; Set = 1'b0;
      LerMem = 1'b0; EscMem = 1'b0; EscIR = 1'b0; EscPC = 1'b0;
      if ((state == EXEC) || (state == MEM) || (state == ESCRITA)) begin
         RegDst   = (op_r == 3'b000);
         RegFonte = (op_r == 3'b010) || (op_r == 3'b101);
         Set      = (op_r == 3'b010);
         ULA1     = (op_r == 3'b010) || (op_r == 3'b011) || (op_r == 3'b101);
         ULA2     = ULA1;
      end
      case (state)
         BUSCA: begin
            LerMem = 1'b1;
            EscIR  = MemPronto;
         end
         EXEC: begin
            Beq   = (op_r == 3'b011);
            Salto = (op_r == 3'b100);
            EscPC = Beq || Salto;
         end
         MEM: begin
            LerMem = (op_r == 3'b000);
            EscMem = (op_r == 3'b001);
            EscPC  = EscMem && MemPronto;
         end
         ESCRITA: begin
            EscReg = 1'b1;
            EscPC  = 1'b1;
         end
         PARADO:  Halt = 1'b1;
         default: ;
      endcase
   end

   assign ULAOp  = op_r;
   assign Estado = state;

   always_ff @(posedge clock) begin
      if (!reset) begin
         op_r       <= 3'b000;
         wait_cnt   <= '0;
         Erro       <= 1'b0;
         InstrCount <= '0;
      end else begin
         if (state == DECOD) op_r <= OpCode[2:0];
         if (state_next != state) wait_cnt <= '0;
         else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
         if (trap)  Erro       <= 1'b1;
         if (EscPC) InstrCount <= InstrCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed scenarios plus random instruction streams,
// checked cycle by cycle against an instruction-level trace model.
module tb_controle_multiciclo;

   localparam int OW = 4;
   localparam int T  = 4;
   localparam int CW = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [OW-1:0] OpCode;
   logic          MemPronto;
   logic Halt, RegFonte, RegDst, EscReg, ULA1, ULA2, Beq, Salto, Set, LerMem, EscMem;
   logic [2:0]    ULAOp;
   logic          EscIR, EscPC, Erro;
   logic [2:0]    Estado;
   logic [CW-1:0] InstrCount;

   controle_multiciclo #(.OPCODE_W(OW), .TIMEOUT(T), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .OpCode(OpCode), .MemPronto(MemPronto),
      .Halt(Halt), .RegFonte(RegFonte), .RegDst(RegDst), .EscReg(EscReg),
      .ULA1(ULA1), .ULA2(ULA2), .Beq(Beq), .Salto(Salto), .Set(Set),
      .LerMem(LerMem), .EscMem(EscMem), .ULAOp(ULAOp), .EscIR(EscIR),
      .EscPC(EscPC), .Erro(Erro), .Estado(Estado), .InstrCount(InstrCount)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic halt, regfonte, regdst, escreg, ula1, ula2, beq, salto, set;
      logic lermem, escmem, escir, escpc;
   } outs_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_exp  = 0;
   logic       erro_exp  = 1'b0;
   logic [2:0] ulaop_exp = 3'b000;
   int n_steps = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected control lines for one cycle of a phase, from the instruction table.
   function automatic outs_t ov(input int ph, input logic [2:0] op, input logic mp);
      outs_t o;
      o = '0;
      case (ph)
         0: begin o.lermem = 1'b1; o.escir = mp; end
         5: o.halt = 1'b1;
         2, 3, 4: begin
            o.regdst   = (op == 3'd0);
            o.regfonte = (op == 3'd2) || (op == 3'd5);
            o.set      = (op == 3'd2);
            o.ula1     = (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
            o.ula2     = o.ula1;
            if (ph == 2) begin
               o.beq   = (op == 3'd3);
               o.salto = (op == 3'd4);
               o.escpc = (op == 3'd3) || (op == 3'd4);
            end else if (ph == 3) begin
               o.lermem = (op == 3'd0);
               o.escmem = (op == 3'd1);
               o.escpc  = (op == 3'd1) && mp;
            end else begin
               o.escreg = 1'b1;
               o.escpc  = 1'b1;
            end
         end
         default: ;
      endcase
      return o;
   endfunction

   // Called at a negedge; drives inputs, checks this cycle, returns at the next negedge.
   task automatic step(input int ph, input logic mp, input logic [OW-1:0] oc);
      outs_t e, a;
      MemPronto = mp;
      OpCode    = oc;
      #1;
      e = ov(ph, ulaop_exp, mp);
      a = {Halt, RegFonte, RegDst, EscReg, ULA1, ULA2, Beq, Salto, Set,
           LerMem, EscMem, EscIR, EscPC};
      check($sformatf("estado ph%0d", ph), 32'(Estado), 32'(ph));
      check($sformatf("outs ph%0d", ph), 32'(a), 32'(e));
      check("erro", 32'(Erro), 32'(erro_exp));
      check("ulaop", 32'(ULAOp), 32'(ulaop_exp));
      check("instrcount", 32'(InstrCount), 32'(cnt_exp));
      n_steps++;
      if (e.escpc) cnt_exp = (cnt_exp + 1) % (1 << CW);
      if (ph == 1) ulaop_exp = oc[2:0];
      if (!reset) begin
         cnt_exp = 0; erro_exp = 1'b0; ulaop_exp = 3'b000;
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      MemPronto = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cnt_exp = 0; erro_exp = 1'b0; ulaop_exp = 3'b000;
   endtask

   // One instruction: fw/mw are the number of not-ready cycles before MemPronto.
   task automatic run_instr(input logic [OW-1:0] oc, input int fw, input int mw,
                            output logic halted);
      logic ill;
      halted = 1'b0;
      for (int i = 0; i < fw && i < T; i++) step(0, 1'b0, oc);
      if (fw >= T) begin
         erro_exp = 1'b1;
         step(5, 1'b0, oc); step(5, 1'b1, oc);
         halted = 1'b1;
         return;
      end
      step(0, 1'b1, oc);
      step(1, 1'($urandom_range(0, 1)), oc);
      ill = ((oc >> 3) != 0) || (oc[2:0] == 3'b110);
      if (ill || oc[2:0] == 3'b111) begin
         if (ill) erro_exp = 1'b1;
         step(5, 1'b0, oc); step(5, 1'b1, oc);
         halted = 1'b1;
         return;
      end
      step(2, 1'($urandom_range(0, 1)), oc);
      case (oc[2:0])
         3'd0, 3'd1: begin
            for (int i = 0; i < mw && i < T; i++) step(3, 1'b0, oc);
            if (mw >= T) begin
               erro_exp = 1'b1;
               step(5, 1'b0, oc); step(5, 1'b1, oc);
               halted = 1'b1;
               return;
            end
            step(3, 1'b1, oc);
            if (oc[2:0] == 3'd0) step(4, 1'b0, oc);
         end
         3'd2, 3'd5: step(4, 1'b0, oc);
         default: ;
      endcase
   endtask

   initial begin
      logic h;
      int   r, fw, mw;
      logic [OW-1:0] oc;
      int   jexp [5] = '{1, 2, 3, 0, 1};

      reset = 1'b0; MemPronto = 1'b0; OpCode = '0;
      @(negedge clock);
      do_reset();

      // reset state, then add with memory always ready
      n_steps = 0;
      run_instr(4'b0010, 0, 0, h);
      check("add_latency", 32'(n_steps), 32'd4);
      check("add_count", 32'(InstrCount), 32'd1);

      // lw with MemPronto held off two cycles in MEM
      n_steps = 0;
      run_instr(4'b0000, 0, 2, h);
      check("lw_latency", 32'(n_steps), 32'd7);

      // illegal 110 and upper-bit opcodes trap; hlt halts cleanly
      run_instr(4'b0110, 0, 0, h);
      check("ill110_erro", 32'(Erro), 32'd1);
      do_reset();
      run_instr(4'b1001, 1, 0, h);
      check("illhi_erro", 32'(Erro), 32'd1);
      do_reset();
      run_instr(4'b0111, 0, 0, h);
      check("hlt_halt", 32'(Halt), 32'd1);
      check("hlt_erro", 32'(Erro), 32'd0);
      do_reset();

      // fetch timeout vs. MemPronto arriving on the last allowed cycle
      run_instr(4'b0100, T, 0, h);
      check("fetch_timeout", 32'(Erro), 32'd1);
      do_reset();
      run_instr(4'b0100, T - 1, 0, h);
      check("fetch_late_ok", 32'(Erro), 32'd0);
      run_instr(4'b0001, 0, T, h);
      check("mem_timeout", 32'(Erro), 32'd1);
      do_reset();

      // counter wrap over five jumps
      for (int i = 0; i < 5; i++) begin
         run_instr(4'b0100, 0, 0, h);
         check($sformatf("jcount%0d", i), 32'(InstrCount), 32'(jexp[i]));
      end

      // reset taken in the middle of a store
      do_reset();
      step(0, 1'b1, 4'b0001);
      step(1, 1'b1, 4'b0001);
      step(2, 1'b1, 4'b0001);
      step(3, 1'b0, 4'b0001);
      reset = 1'b0;
      step(3, 1'b0, 4'b0001);
      step(0, 1'b0, 4'b0001);
      reset = 1'b1;

      // random instruction stream
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 19);
         if (r < 14)       oc = OW'($urandom_range(0, 5));
         else if (r < 16)  oc = 4'b0110;
         else if (r == 16) oc = 4'b0111;
         else              oc = {1'b1, 3'($urandom_range(0, 7))};
         fw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         mw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         run_instr(oc, fw, mw, h);
         if (h) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
